// File: rtl/pps_src_ctrl.sv
// PPS reference-selection controller: qualifies external PPS inputs by period
// and steers pps_gen's select/enable, switching only on a generator pulse edge.
module pps_src_ctrl #(
    parameter int NSRC     = 4,
    parameter int CLK_FREQ = 100000000,
    parameter int TOL      = 1000,
    parameter int GOOD_CNT = 3,
    parameter int CNT_W    = 28
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic            ctrl_en_i,
    input  logic [NSRC-1:0] src_mask_i,
    input  logic            force_sel_i,
    input  logic [2:0]      force_idx_i,
    input  logic [NSRC-1:0] src_pps_i,
    input  logic            gen_pps_i,
    output logic [2:0]      pps_sel_o,
    output logic            pps_en_o,
    output logic [NSRC-1:0] src_valid_o,
    output logic            holdover_o,
    output logic            switch_pulse_o
);
    localparam int GW = $clog2(GOOD_CNT + 1);
    localparam logic [CNT_W-1:0] SAT      = CNT_W'(CLK_FREQ + TOL + 1);
    localparam logic [CNT_W:0]   SAT_X    = (CNT_W+1)'(CLK_FREQ + TOL + 1);
    localparam logic [CNT_W:0]   LO       = (CNT_W+1)'(CLK_FREQ - TOL);
    localparam logic [CNT_W:0]   HI       = (CNT_W+1)'(CLK_FREQ + TOL);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(CLK_FREQ + TOL);
    localparam logic [GW-1:0]    GFULL    = GW'(GOOD_CNT);

    typedef enum logic [1:0] {IDLE, RUN, SWITCH_WAIT} state_t;

    logic [NSRC-1:0]  s1, s2, s3, rise, full, valid, valid_d;
    logic [CNT_W-1:0] cnt  [NSRC];
    logic [CNT_W:0]   meas [NSRC];
    logic [GW-1:0]    good [NSRC];

    state_t           state, state_n;
    logic [2:0]       sel, sel_n, tgt, tgt_n, desired;
    logic [CNT_W-1:0] wcnt, wcnt_n;
    logic             strobe, strobe_n, gen_d, gen_edge, lost, found;

    assign rise     = s2 & ~s3;
    assign gen_edge = gen_pps_i & ~gen_d;

    // meas is the period length including the current cycle
    always_comb begin
        for (int unsigned i = 0; i < NSRC; i++) begin
            meas[i] = {1'b0, cnt[i]} + 1'b1;
            full[i] = (good[i] == GFULL);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
            for (int unsigned i = 0; i < NSRC; i++) begin
                cnt[i]  <= SAT;
                good[i] <= '0;
            end
        end else begin
            s1 <= src_pps_i;
            s2 <= s1;
            s3 <= s2;
            for (int unsigned i = 0; i < NSRC; i++) begin
                if (rise[i]) begin
                    if (meas[i] >= LO && meas[i] <= HI) begin
                        if (good[i] != GFULL) good[i] <= good[i] + 1'b1;
                    end else begin
                        good[i] <= '0;
                    end
                    cnt[i] <= '0;
                end else if (cnt[i] != SAT) begin
                    cnt[i] <= cnt[i] + 1'b1;
                    if (meas[i] == SAT_X) good[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            valid   <= '0;
            valid_d <= '0;
        end else begin
            valid   <= full & src_mask_i;
            valid_d <= valid;
        end
    end

    always_comb begin
        desired = '0;
        found   = 1'b0;
        if (force_sel_i) begin
            if (force_idx_i <= 3'(NSRC)) desired = force_idx_i;
        end else begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                if (valid[i] && !found) begin
                    desired = 3'(i + 1);
                    found   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        lost = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (sel == 3'(i + 1) && valid_d[i] && !valid[i]) lost = 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state  <= IDLE;
            sel    <= '0;
            tgt    <= '0;
            wcnt   <= '0;
            strobe <= 1'b0;
            gen_d  <= 1'b0;
        end else begin
            state  <= state_n;
            sel    <= sel_n;
            tgt    <= tgt_n;
            wcnt   <= wcnt_n;
            strobe <= strobe_n;
            gen_d  <= gen_pps_i;
        end
    end

    // Loss of the active source bypasses the pulse-edge alignment wait
    always_comb begin
        state_n  = state;
        sel_n    = sel;
        tgt_n    = tgt;
        wcnt_n   = wcnt;
        strobe_n = 1'b0;
        if (!ctrl_en_i) begin
            state_n = IDLE;
            sel_n   = '0;
            tgt_n   = '0;
            wcnt_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n  = RUN;
                    sel_n    = desired;
                    strobe_n = (desired != 3'd0);
                end
                RUN: begin
                    if (lost) begin
                        sel_n    = desired;
                        strobe_n = (desired != sel);
                    end else if (desired != sel) begin
                        state_n = SWITCH_WAIT;
                        tgt_n   = desired;
                        wcnt_n  = '0;
                    end
                end
                SWITCH_WAIT: begin
                    if (lost) begin
                        state_n  = RUN;
                        sel_n    = desired;
                        strobe_n = (desired != sel);
                    end else if (desired == sel) begin
                        state_n = RUN;
                    end else if (gen_edge || wcnt == WAIT_MAX) begin
                        state_n  = RUN;
                        sel_n    = tgt;
                        strobe_n = 1'b1;
                    end else begin
                        tgt_n  = desired;
                        wcnt_n = wcnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        pps_sel_o      = sel;
        pps_en_o       = (state != IDLE);
        holdover_o     = (state != IDLE) && (sel == 3'd0);
        switch_pulse_o = strobe;
        src_valid_o    = valid;
    end
endmodule

// File: tb/tb_pps_src_ctrl.sv
// Bench for pps_src_ctrl: scheduled/jittered PPS stimulus checked every cycle
// against a timestamp-based reference model, plus milestone checks.
module tb_pps_src_ctrl;
    localparam int NSRC = 4;
    localparam int CF   = 1000;
    localparam int TOL  = 10;
    localparam int G    = 3;
    localparam int CW   = 12;

    logic       aclk = 1'b0;
    logic       areset, ctrl_en, force_sel, gen;
    logic [3:0] mask, raw;
    logic [2:0] force_idx;
    logic [2:0] pps_sel;
    logic       pps_en, holdover, switch_pulse;
    logic [3:0] src_valid;

    pps_src_ctrl #(.NSRC(NSRC), .CLK_FREQ(CF), .TOL(TOL), .GOOD_CNT(G), .CNT_W(CW)) dut (
        .aclk(aclk), .areset(areset), .ctrl_en_i(ctrl_en), .src_mask_i(mask),
        .force_sel_i(force_sel), .force_idx_i(force_idx), .src_pps_i(raw),
        .gen_pps_i(gen), .pps_sel_o(pps_sel), .pps_en_o(pps_en),
        .src_valid_o(src_valid), .holdover_o(holdover), .switch_pulse_o(switch_pulse)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    // stimulus scheduler state
    longint n = 0;
    longint next_rise [NSRC];
    longint hi_until  [NSRC];
    int     per [NSRC];
    int     jit [NSRC];
    int     s1q [$];
    int     gen_per = 0;
    longint gen_next = 0, gen_until = 0;

    // reference model state
    longint k = 0;
    int     m_good [NSRC];
    longint m_last [NSRC];
    bit [3:0] m_r1, m_r2, m_praw, m_valid, m_vprev;
    bit     m_on, m_pend, m_strobe, m_pgen;
    int     m_sel, m_tgt;
    longint m_wstart;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at step %0d", tag, got, exp, k);
        end
    endtask

    function automatic int desired_code(bit fs, int fi, bit [3:0] v);
        if (fs) return (fi <= NSRC) ? fi : 0;
        for (int i = 0; i < NSRC; i++) if (v[i]) return i + 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NSRC; i++) begin
            m_good[i] = 0;
            m_last[i] = -1;
        end
        m_r1 = '0; m_r2 = '0; m_praw = '0; m_valid = '0; m_vprev = '0;
        m_on = 0; m_pend = 0; m_strobe = 0; m_pgen = 0;
        m_sel = 0; m_tgt = 0; m_wstart = 0;
    endtask

    task automatic model_step();
        bit [3:0] nv, rise;
        int des;
        bit grise, lost;
        longint dt;
        if (areset) begin
            model_reset();
            k++;
            return;
        end
        for (int i = 0; i < NSRC; i++) begin
            nv[i] = (m_good[i] == G) && mask[i];
            dt = k - m_last[i];
            if (m_r2[i]) begin
                if (m_last[i] >= 0 && dt >= CF - TOL && dt <= CF + TOL)
                    m_good[i] = (m_good[i] < G) ? m_good[i] + 1 : G;
                else
                    m_good[i] = 0;
                m_last[i] = k;
            end else if (m_last[i] >= 0 && dt == CF + TOL + 1) begin
                m_good[i] = 0;
            end
        end
        rise   = raw & ~m_praw;
        m_r2   = m_r1;
        m_r1   = rise;
        m_praw = raw;

        des    = desired_code(force_sel, int'(force_idx), m_valid);
        grise  = gen && !m_pgen;
        m_pgen = gen;
        lost   = (m_sel != 0) && m_vprev[m_sel-1] && !m_valid[m_sel-1];
        m_strobe = 0;
        if (!ctrl_en) begin
            m_on = 0; m_pend = 0; m_sel = 0;
        end else if (!m_on) begin
            m_on = 1; m_pend = 0;
            m_strobe = (des != m_sel);
            m_sel = des;
        end else if (lost) begin
            m_strobe = (des != m_sel);
            m_sel = des;
            m_pend = 0;
        end else if (!m_pend) begin
            if (des != m_sel) begin
                m_pend = 1; m_tgt = des; m_wstart = k;
            end
        end else if (des == m_sel) begin
            m_pend = 0;
        end else if (grise || (k - m_wstart) == CF + TOL + 1) begin
            m_strobe = (m_tgt != m_sel);
            m_sel = m_tgt;
            m_pend = 0;
        end else begin
            m_tgt = des;
        end
        m_vprev = m_valid;
        m_valid = nv;
        k++;
    endtask

    task automatic drive();
        for (int i = 0; i < NSRC; i++) begin
            if (per[i] != 0 && n >= next_rise[i]) begin
                int p;
                hi_until[i] = n + 4;
                if (i == 1 && s1q.size() > 0) p = s1q.pop_front();
                else p = per[i] + int'($urandom_range(0, 2 * jit[i])) - jit[i];
                next_rise[i] += p;
            end
            raw[i] = (n < hi_until[i]);
        end
        if (gen_per != 0 && n >= gen_next) begin
            gen_until = n + 3;
            gen_next += gen_per + int'($urandom_range(0, 40)) - 20;
        end
        gen = (n < gen_until);
        n++;
    endtask

    task automatic check_outputs();
        chk("sel",    32'(pps_sel),      32'(m_sel));
        chk("en",     32'(pps_en),       32'(m_on));
        chk("valid",  32'(src_valid),    32'(m_valid));
        chk("hold",   32'(holdover),     32'(m_on && m_sel == 0));
        chk("strobe", 32'(switch_pulse), 32'(m_strobe));
    endtask

    task automatic run(input int cycles);
        repeat (cycles) begin
            drive();
            @(posedge aclk);
            model_step();
            @(negedge aclk);
            check_outputs();
        end
    endtask

    task automatic start_src(input int i, input int p, input int j);
        per[i] = p;
        jit[i] = j;
        next_rise[i] = n + $urandom_range(2, 40);
    endtask

    task automatic start_gen();
        gen_per  = CF;
        gen_next = n + $urandom_range(5, 900);
    endtask

    initial begin
        areset = 1'b1; ctrl_en = 1'b0; force_sel = 1'b0; force_idx = '0;
        mask = 4'hF; raw = '0; gen = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            per[i] = 0; jit[i] = 0; next_rise[i] = 0; hi_until[i] = 0;
        end
        model_reset();
        run(3);
        chk("rst_sel", 32'(pps_sel), 0);
        chk("rst_valid", 32'(src_valid), 0);
        areset = 1'b0;
        ctrl_en = 1'b1;
        start_gen();

        // qualification of src0
        start_src(0, CF, 10);
        run(6000);
        chk("qual_valid", 32'(src_valid), 32'h1);
        chk("qual_sel", 32'(pps_sel), 1);
        chk("qual_hold", 32'(holdover), 0);

        // tolerance boundaries on src1
        s1q = '{989, 1011, 989, 1011, 990, 1010, 990, 1010};
        start_src(1, CF, 0);
        run(4500);
        chk("tol_bad", 32'(src_valid[1]), 0);
        run(4000);
        chk("tol_good", 32'(src_valid), 32'h3);
        chk("tol_sel", 32'(pps_sel), 1);

        // loss of src0 falls back to src1, then src0 requalifies with priority
        per[0] = 0;
        run(2100);
        chk("loss_sel", 32'(pps_sel), 2);
        chk("loss_valid", 32'(src_valid), 32'h2);
        start_src(0, CF, 10);
        run(5500);
        chk("prio_sel", 32'(pps_sel), 1);

        // lose everything -> holdover
        per[0] = 0;
        run(2100);
        chk("loss2_sel", 32'(pps_sel), 2);
        per[1] = 0;
        run(2100);
        chk("hold_sel", 32'(pps_sel), 0);
        chk("hold_flag", 32'(holdover), 1);
        chk("hold_en", 32'(pps_en), 1);

        // forced selection
        force_sel = 1'b1; force_idx = 3'd3;
        run(1200);
        chk("force3", 32'(pps_sel), 3);
        force_idx = 3'd6;
        run(1200);
        chk("force6", 32'(pps_sel), 0);
        for (int r = 0; r < 4; r++) begin
            force_idx = 3'($urandom_range(0, 7));
            run(300);
        end

        // enable drop while waiting for alignment
        force_idx = 3'd1;
        run(1200);
        chk("pre_drop_sel", 32'(pps_sel), 1);
        gen_per = 0;
        run(10);
        force_idx = 3'd2;
        run(20);
        chk("wait_hold_sel", 32'(pps_sel), 1);
        ctrl_en = 1'b0;
        run(1);
        chk("drop_en", 32'(pps_en), 0);
        chk("drop_sel", 32'(pps_sel), 0);
        chk("drop_strobe", 32'(switch_pulse), 0);
        ctrl_en = 1'b1;
        run(1);
        chk("reen_sel", 32'(pps_sel), 2);
        run(20);

        // alignment timeout with no generator pulses
        force_idx = 3'd4;
        run(1000);
        chk("tmo_wait", 32'(pps_sel), 2);
        run(30);
        chk("tmo_apply", 32'(pps_sel), 4);

        // reset mid-switch
        force_idx = 3'd1;
        run(10);
        areset = 1'b1;
        run(2);
        chk("ares_en", 32'(pps_en), 0);
        chk("ares_sel", 32'(pps_sel), 0);
        chk("ares_valid", 32'(src_valid), 0);
        areset = 1'b0;
        run(1);
        chk("post_rst_sel", 32'(pps_sel), 1);
        run(20);

        // randomized mix: masks, enable glitches, mixed-quality sources
        force_sel = 1'b0;
        start_gen();
        start_src(0, CF, 10);
        start_src(1, CF, 10);
        start_src(2, 995, 5);
        start_src(3, 1200, 0);
        for (int r = 0; r < 10; r++) begin
            mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) begin
                ctrl_en = 1'b0;
                run(3);
                ctrl_en = 1'b1;
            end
            run(800);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pps_src_ctrl.md
Name: pps_src_ctrl

Overview:
- Reference-selection controller that drives the configuration inputs of pps_gen: its select input and its enable input.
- Qualifies up to NSRC external PPS inputs by measuring their periods, picks the source to use (priority order or forced), and produces pps_sel_o and pps_en_o.
- Selection changes are applied on a pulse edge of pps_gen's own output, so a switch never truncates a pulse.
- Sits between the PPS input pins and pps_gen in the timing subsystem.

Parameters:
- NSRC, 4, number of external PPS inputs (1..7).
- CLK_FREQ, 100000000, nominal PPS period in aclk cycles.
- TOL, 1000, allowed period deviation in cycles (±).
- GOOD_CNT, 3, consecutive in-tolerance periods required to qualify a source.
- CNT_W, 28, period counter width; must satisfy 2^CNT_W > CLK_FREQ+TOL+1.

Ports:
- aclk  in  1  system clock, 100 MHz.
- areset  in  1  asynchronous, active-high reset.
- ctrl_en_i  in  1  master enable.
- src_mask_i  in  NSRC  per-source permit; 0 disqualifies that source.
- force_sel_i  in  1  manual override enable.
- force_idx_i  in  3  manual selection code when force_sel_i=1.
- src_pps_i  in  NSRC  raw PPS inputs, asynchronous to aclk.
- gen_pps_i  in  1  pps_out fed back from pps_gen, synchronous to aclk.
- pps_sel_o  out  3  to pps_gen pps_sel_i. 0 = internal free-run; k = source k-1.
- pps_en_o  out  1  to pps_gen pps_en_i.
- src_valid_o  out  NSRC  per-source qualified flags.
- holdover_o  out  1  high when pps_en_o=1 and pps_sel_o=0.
- switch_pulse_o  out  1  one-cycle strobe when pps_sel_o changes.

Behaviour:
- Reset: all outputs 0, state IDLE, every monitor count = saturated, every good count = 0.
- Source monitor, one per source i:
  - 2-flop synchronizer, then rising-edge detect; the edge is seen 3 aclk cycles after the input rises.
  - Counter increments each cycle and saturates at CLK_FREQ+TOL+1.
  - On an edge:
    - count in [CLK_FREQ-TOL, CLK_FREQ+TOL] → good count +1, saturating at GOOD_CNT.
    - otherwise → good count = 0.
    - count is then cleared to 0.
  - Count reaching CLK_FREQ+TOL+1 (timeout) → good count = 0.
  - src_valid_o[i] = (good count == GOOD_CNT) & src_mask_i[i], registered.
  - The first edge after reset is always bad, so a clean source qualifies on its GOOD_CNT+1-th edge.
- Desired code:
  - force_sel_i=1 → force_idx_i if ≤ NSRC, else 0.
  - Otherwise → lowest valid index + 1, or 0 when no source is valid.
- FSM states:
  - IDLE:
    - pps_en_o=0, pps_sel_o=0.
    - ctrl_en_i=1 → RUN. On the next cycle pps_en_o=1 and pps_sel_o=desired, with no edge alignment (generator was disabled).
  - RUN:
    - desired ≠ pps_sel_o → latch target, go to SWITCH_WAIT.
  - SWITCH_WAIT:
    - Desired changes → re-latch target.
    - Desired == pps_sel_o → back to RUN, no switch, no strobe.
    - Rising edge of gen_pps_i (registered edge detect) → pps_sel_o=target next cycle, switch_pulse_o=1 for that cycle, go to RUN.
    - Wait counter reaches CLK_FREQ+TOL with no gen_pps_i edge → apply the switch anyway.
- Loss of the current source (pps_sel_o=k≠0 and src_valid_o[k-1] falls):
  - From RUN or SWITCH_WAIT, switch on the next cycle with no alignment wait.
  - Target is the current desired value; switch_pulse_o is asserted.
- ctrl_en_i=0 in any state → IDLE next cycle. pps_en_o=0 and pps_sel_o=0; no strobe.
- areset mid-switch → IDLE, pending target discarded.
- Monitors keep running in every state, including IDLE.

Test Plan (NSRC=4, CLK_FREQ=1000, TOL=10, GOOD_CNT=3):
- Qualification: ctrl_en_i=1, mask=4'hF, src0 pulses every 1000 cycles.
  - After the 4th src0 edge (+3 cycles sync), src_valid_o=4'b0001.
  - pps_sel_o goes 1 on the next gen_pps_i edge, with switch_pulse_o=1 for 1 cycle.
  - holdover_o falls.
- Tolerance: src1 periods of 989, then 1011 → valid never set; periods of 990 and 1010 → valid after 4 edges.
- Priority and alignment: src1 valid and selected (sel=2), then src0 qualifies.
  - sel holds at 2 until the next gen_pps_i rising edge, then becomes 1 on the following cycle.
- Loss: src0 selected, src0 stops.
  - After 1011 cycles with no edge, valid[0]=0.
  - Next cycle sel=2 (src1 valid) with no edge wait; with no valid source, sel=0 and holdover_o=1.
- Force: force_sel_i=1, force_idx_i=3 with src2 not valid → sel=3 on the next gen edge. force_idx_i=6 → sel=0.
- Enable and reset: ctrl_en_i dropped while in SWITCH_WAIT → next cycle pps_en_o=0, sel=0, no strobe. areset pulse → all outputs 0 and all valids cleared.
